classifier_cfg_ctrl: RTL and testbench

- Configuration controller for the seizure-event classifier.
- Holds host-written shadow values for class A threshold, class B threshold and timeout period.
- Validates the set on commit and applies it only after the classifier has reported event C (quiet) for a programmable run of consecutive samples. Thresholds therefore never change mid-event.
- Sits between the host register interface and the classifier `*_in` config ports. Its event input is fed from the classifier `event_out`.

---
 rtl/classifier_cfg_ctrl_if.sv | 38 +++
 rtl/classifier_cfg_ctrl.sv | 136 +++++++++++++
 tb/tb_classifier_cfg_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/classifier_cfg_ctrl_if.sv
// Host/classifier-facing signal bundle for classifier_cfg_ctrl.
// force_commit exists only when CLASSIFIER_CFG_FORCE_EN is defined.
interface classifier_cfg_ctrl_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit_req;
    logic        err_clr;
    logic [1:0]  event_in;
`ifdef CLASSIFIER_CFG_FORCE_EN
    logic        force_commit;
`endif
    logic [7:0]  class_a_thresh_out;
    logic [7:0]  class_b_thresh_out;
    logic [15:0] timeout_period_out;
    logic        busy;
    logic        commit_ack;
    logic        commit_nack;
    logic [1:0]  cfg_err;

    modport master (
`ifdef CLASSIFIER_CFG_FORCE_EN
        output force_commit,
`endif
        output wr_en, wr_addr, wr_data, commit_req, err_clr, event_in,
        input  class_a_thresh_out, class_b_thresh_out, timeout_period_out,
        input  busy, commit_ack, commit_nack, cfg_err
    );

    modport slave (
`ifdef CLASSIFIER_CFG_FORCE_EN
        input  force_commit,
`endif
        input  wr_en, wr_addr, wr_data, commit_req, err_clr, event_in,
        output class_a_thresh_out, class_b_thresh_out, timeout_period_out,
        output busy, commit_ack, commit_nack, cfg_err
    );
endinterface

// File: rtl/classifier_cfg_ctrl.sv
// Classifier config controller: shadow regs, commit validation, apply after a quiet run.
// Optional CLASSIFIER_CFG_FORCE_EN adds force_commit to bypass the quiet wait.
module classifier_cfg_ctrl #(
    parameter int unsigned QUIET_CYCLES = 2000,
    parameter int unsigned MAX_WAIT     = 100000,
    parameter int unsigned DEF_A_THRESH = 5,
    parameter int unsigned DEF_B_THRESH = 1,
    parameter int unsigned DEF_TIMEOUT  = 10000
) (
    input logic                  clk,
    input logic                  reset,
    classifier_cfg_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] tmo;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{a: 8'(DEF_A_THRESH), b: 8'(DEF_B_THRESH), tmo: 16'(DEF_TIMEOUT)};

    typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

    state_t           r_state, w_next_state;
    cfg_t             r_shadow, r_stage, r_out;
    logic [CNT_W-1:0] r_quiet_cnt, r_wait_cnt;
    logic             r_busy, r_ack, r_nack;
    logic [1:0]       r_cfg_err;

    logic       w_valid, w_quiet, w_force, w_load_stage, w_ack, w_nack;
    logic [1:0] w_err_set;

    assign w_valid = (r_shadow.b != 8'd0) && (r_shadow.a > r_shadow.b) && (r_shadow.tmo != 16'd0);
    assign w_quiet = (bus.event_in == 2'b00);
`ifdef CLASSIFIER_CFG_FORCE_EN
    assign w_force = bus.force_commit;
`else
    assign w_force = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and strobe decode; apply wins over wait timeout
    always_comb begin
        w_next_state = r_state;
        w_load_stage = 1'b0;
        w_ack        = 1'b0;
        w_nack       = 1'b0;
        w_err_set    = 2'b00;
        case (r_state)
            IDLE: begin
                if (bus.commit_req) begin
                    if (w_valid) begin
                        w_load_stage = 1'b1;
                        w_next_state = w_force ? APPLY : PENDING;
                    end else begin
                        w_nack       = 1'b1;
                        w_err_set[0] = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (w_force || (w_quiet && (r_quiet_cnt == QUIET_LAST))) begin
                    w_next_state = APPLY;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = IDLE;
                    w_nack       = 1'b1;
                    w_err_set[1] = 1'b1;
                end
            end
            APPLY: begin
                w_next_state = IDLE;
                w_ack        = 1'b1;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Shadow registers are writable in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= DEF_CFG;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                2'd0:    r_shadow.a   <= bus.wr_data[7:0];
                2'd1:    r_shadow.b   <= bus.wr_data[7:0];
                2'd2:    r_shadow.tmo <= bus.wr_data;
                default: ;
            endcase
        end
    end

    // Staging, quiet/wait counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage     <= DEF_CFG;
            r_out       <= DEF_CFG;
            r_quiet_cnt <= '0;
            r_wait_cnt  <= '0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_nack      <= 1'b0;
            r_cfg_err   <= 2'b00;
        end else begin
            if (w_load_stage) begin
                r_stage     <= r_shadow;
                r_quiet_cnt <= '0;
                r_wait_cnt  <= '0;
            end else if (r_state == PENDING) begin
                r_quiet_cnt <= w_quiet ? (r_quiet_cnt + CNT_W'(1)) : '0;
                r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
            end
            if (w_ack) r_out <= r_stage;
            r_busy    <= (w_next_state != IDLE);
            r_ack     <= w_ack;
            r_nack    <= w_nack;
            r_cfg_err <= (bus.err_clr ? 2'b00 : r_cfg_err) | w_err_set;
        end
    end

    assign bus.class_a_thresh_out = r_out.a;
    assign bus.class_b_thresh_out = r_out.b;
    assign bus.timeout_period_out = r_out.tmo;
    assign bus.busy               = r_busy;
    assign bus.commit_ack         = r_ack;
    assign bus.commit_nack        = r_nack;
    assign bus.cfg_err            = r_cfg_err;
endmodule

// File: tb/tb_classifier_cfg_ctrl.sv
// Directed bench for classifier_cfg_ctrl (QUIET_CYCLES=4, MAX_WAIT=16).
// Inputs change and outputs are sampled on the falling edge; cycle N = N rising edges after commit.
module tb_classifier_cfg_ctrl;
    localparam int unsigned QC = 4;
    localparam int unsigned MW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    classifier_cfg_ctrl_if bus ();

    classifier_cfg_ctrl #(
        .QUIET_CYCLES(QC), .MAX_WAIT(MW),
        .DEF_A_THRESH(5), .DEF_B_THRESH(1), .DEF_TIMEOUT(10000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ea = 5, eb = 1, et = 10000;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] t;
        bit          ok;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    task automatic check_outs(input string nm);
        check({nm, " a"}, bus.class_a_thresh_out, ea);
        check({nm, " b"}, bus.class_b_thresh_out, eb);
        check({nm, " t"}, bus.timeout_period_out, et);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wr_set(input logic [7:0] a, input logic [7:0] b, input logic [15:0] t);
        wr(2'd0, {8'd0, a}); wr(2'd1, {8'd0, b}); wr(2'd2, t);
    endtask

    task automatic commit(input logic [1:0] ev0);
        bus.commit_req = 1'b1; bus.event_in = ev0;
        @(negedge clk);
        bus.commit_req = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    // Walk cycles 1..maxc, driving event schedule; stop at first ack/nack
    task automatic observe(input logic [63:0] sched, input int maxc,
                           output int ack_c, output int nack_c, output int busy_seen);
        ack_c = -1; nack_c = -1; busy_seen = 0;
        for (int c = 1; c <= maxc; c++) begin
            if (bus.busy === 1'b1) busy_seen = 1;
            if (bus.commit_ack === 1'b1) ack_c = c;
            if (bus.commit_nack === 1'b1) nack_c = c;
            if (ack_c >= 0 || nack_c >= 0) break;
            bus.event_in = (c < 32) ? sched[2*c +: 2] : 2'b00;
            @(negedge clk);
        end
        bus.event_in = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ack_c, nack_c, bs;
        bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 16'd0;
        bus.commit_req = 1'b0; bus.err_clr = 1'b0; bus.event_in = 2'b00;
`ifdef CLASSIFIER_CFG_FORCE_EN
        bus.force_commit = 1'b0;
`endif
        vt[0] = '{a: 8'd8,   b: 8'd3,   t: 16'd500,   ok: 1'b1};
        vt[1] = '{a: 8'd2,   b: 8'd3,   t: 16'd500,   ok: 1'b0};
        vt[2] = '{a: 8'd3,   b: 8'd3,   t: 16'd500,   ok: 1'b0};
        vt[3] = '{a: 8'd5,   b: 8'd0,   t: 16'd500,   ok: 1'b0};
        vt[4] = '{a: 8'd9,   b: 8'd4,   t: 16'd0,     ok: 1'b0};
        vt[5] = '{a: 8'd2,   b: 8'd1,   t: 16'd1,     ok: 1'b1};
        vt[6] = '{a: 8'd255, b: 8'd254, t: 16'd65535, ok: 1'b1};

        @(negedge clk); @(negedge clk);
        check_outs("reset");
        check("reset busy", bus.busy, 0);
        check("reset err", bus.cfg_err, 0);
        check("reset ack", bus.commit_ack, 0);
        check("reset nack", bus.commit_nack, 0);
        reset = 1'b0;
        @(negedge clk);

        // Validation table, event C held throughout
        for (int i = 0; i < 7; i++) begin
            wr_set(vt[i].a, vt[i].b, vt[i].t);
            commit(2'b00);
            observe(64'h0, 10, ack_c, nack_c, bs);
            if (vt[i].ok) begin
                ea = vt[i].a; eb = vt[i].b; et = vt[i].t;
                check($sformatf("v%0d ack cycle", i), ack_c, QC + 2);
                check($sformatf("v%0d nack cycle", i), nack_c, -1);
                check($sformatf("v%0d busy seen", i), bs, 1);
                check($sformatf("v%0d busy at ack", i), bus.busy, 0);
                check_outs($sformatf("v%0d applied", i));
                check($sformatf("v%0d err", i), bus.cfg_err, 0);
                @(negedge clk);
                check($sformatf("v%0d ack pulse", i), bus.commit_ack, 0);
            end else begin
                check($sformatf("v%0d nack cycle", i), nack_c, 1);
                check($sformatf("v%0d ack cycle", i), ack_c, -1);
                check($sformatf("v%0d busy seen", i), bs, 0);
                check($sformatf("v%0d err", i), bus.cfg_err, 1);
                check_outs($sformatf("v%0d unchanged", i));
                @(negedge clk);
                check($sformatf("v%0d nack pulse", i), bus.commit_nack, 0);
                pulse_clr();
                check($sformatf("v%0d err clr", i), bus.cfg_err, 0);
            end
        end

        // Non-quiet events delay the apply
        wr_set(8'd20, 8'd10, 16'd1234);
        commit(2'b00);
        observe(64'h0A8, 20, ack_c, nack_c, bs);
        ea = 20; eb = 10; et = 1234;
        check("ev A c1-3 ack", ack_c, 9);
        check_outs("ev A c1-3");
        @(negedge clk);
        wr_set(8'd21, 8'd10, 16'd1234);
        commit(2'b00);
        observe(64'h4A8, 20, ack_c, nack_c, bs);
        ea = 21;
        check("ev B restart ack", ack_c, 11);
        check_outs("ev B restart");
        @(negedge clk);
        wr_set(8'd22, 8'd10, 16'd1234);
        commit(2'b00);
        observe(64'hCA8, 20, ack_c, nack_c, bs);
        ea = 22;
        check("ev 11 restart ack", ack_c, 11);
        check_outs("ev 11 restart");
        @(negedge clk);

        // Wait timeout: event A held
        wr_set(8'd50, 8'd40, 16'd77);
        commit(2'b10);
        observe(64'hAAAA_AAAA_AAAA_AAAA, 24, ack_c, nack_c, bs);
        check("timeout nack cycle", nack_c, MW + 1);
        check("timeout ack", ack_c, -1);
        check("timeout err", bus.cfg_err, 2);
        check("timeout busy", bus.busy, 0);
        check_outs("timeout unchanged");
        @(negedge clk);

        // Validation failure alongside err_clr: set wins, other bit clears
        wr(2'd1, 16'd0);
        bus.err_clr = 1'b1;
        commit(2'b00);
        bus.err_clr = 1'b0;
        check("set beats clr err", bus.cfg_err, 1);
        check("set beats clr nack", bus.commit_nack, 1);
        pulse_clr();
        check("clr after both", bus.cfg_err, 0);

        // Pending commit: shadow write and second commit_req are ignored
        wr_set(8'd7, 8'd2, 16'd300);
        commit(2'b00);
        check("pend busy c1", bus.busy, 1);
        @(negedge clk);
        wr(2'd0, 16'd9);
        bus.commit_req = 1'b1;
        @(negedge clk);
        bus.commit_req = 1'b0;
        observe(64'h0, 10, ack_c, nack_c, bs);
        ea = 7; eb = 2; et = 300;
        check("busy recommit ack", ack_c, 3);
        check("busy recommit nack", nack_c, -1);
        check("busy recommit err", bus.cfg_err, 0);
        check_outs("staged pre-write");
        @(negedge clk);
        commit(2'b00);
        observe(64'h0, 10, ack_c, nack_c, bs);
        ea = 9;
        check("late write ack", ack_c, QC + 2);
        check_outs("late write applied");
        @(negedge clk);

        // Reset in the middle of PENDING
        wr(2'd0, 16'd11);
        commit(2'b00);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ea = 5; eb = 1; et = 10000;
        check_outs("mid reset");
        check("mid reset busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);
        observe(64'h0, 8, ack_c, nack_c, bs);
        check("post reset idle ack", ack_c, -1);
        check("post reset idle busy", bs, 0);
        wr(2'd0, 16'd30);
        wr(2'd3, 16'd0);
        commit(2'b00);
        observe(64'h0, 10, ack_c, nack_c, bs);
        ea = 30;
        check("post reset ack", ack_c, QC + 2);
        check_outs("shadow defaults");
        @(negedge clk);

`ifdef CLASSIFIER_CFG_FORCE_EN
        wr_set(8'd40, 8'd20, 16'd99);
        bus.force_commit = 1'b1;
        commit(2'b10);
        bus.force_commit = 1'b0;
        observe(64'hAAAA_AAAA_AAAA_AAAA, 8, ack_c, nack_c, bs);
        ea = 40; eb = 20; et = 99;
        check("force ack cycle", ack_c, 2);
        check_outs("force applied");
        @(negedge clk);
        wr(2'd0, 16'd41);
        commit(2'b10);
        bus.event_in = 2'b10;
        @(negedge clk);
        bus.force_commit = 1'b1;
        @(negedge clk);
        bus.force_commit = 1'b0;
        observe(64'hAAAA_AAAA_AAAA_AAAA, 8, ack_c, nack_c, bs);
        ea = 41;
        check("force pending ack", ack_c, 2);
        check_outs("force pending applied");
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
